// File: rtl/cic_interp_feeder.sv
// Sample FIFO plus output-rate/input-rate strobe generator feeding a CIC interpolator.
// out_data is registered and reloads on each in_rate edge; an empty FIFO at that edge yields 0 and sets underflow.
module cic_interp_feeder #(
  parameter int ISZ        = 16,
  parameter int CLK_DIV    = 4,
  parameter int RATIO      = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [ISZ-1:0]                s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          out_rate,
  output logic                          in_rate,
  output logic [ISZ-1:0]                out_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underflow,
  input  logic                          clear_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [DW-1:0]  div_cnt;
  logic [PW-1:0]  phase_cnt;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [ISZ-1:0] mem [FIFO_DEPTH];
  logic           full, empty, push, pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign s_ready = !reset && !full;
  assign push    = s_valid && s_ready;
  assign in_rate = out_rate && (phase_cnt == '0);
  assign pop     = in_rate && !empty;

  // A strobe already registered still completes in the cycle enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      phase_cnt <= '0;
      out_rate  <= 1'b0;
    end else if (!enable) begin
      div_cnt   <= '0;
      phase_cnt <= '0;
      out_rate  <= 1'b0;
    end else begin
      out_rate <= (div_cnt == DW'(CLK_DIV - 1));
      if (div_cnt == DW'(CLK_DIV - 1))
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DW'(1);
      if (out_rate) begin
        if (phase_cnt == PW'(RATIO - 1))
          phase_cnt <= '0;
        else
          phase_cnt <= phase_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_data  <= '0;
      underflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (in_rate)
        out_data <= empty ? '0 : mem[rd_ptr];
      // Set has priority over a coincident clear.
      if (in_rate && empty)
        underflow <= 1'b1;
      else if (clear_underflow)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_interp_feeder.sv
// Randomized bench: a queue-and-run-length reference model predicts every output each cycle; a negedge monitor compares.
module tb_cic_interp_feeder;
  localparam int ISZ     = 16;
  localparam int CLK_DIV = 3;
  localparam int RATIO   = 2;
  localparam int DEPTH   = 4;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int NCYC    = 4000;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [ISZ-1:0] s_data = '0;
  logic           s_valid = 1'b0;
  logic           clear_underflow = 1'b0;
  logic           s_ready, out_rate, in_rate, underflow;
  logic [ISZ-1:0] out_data;
  logic [LW-1:0]  level;

  cic_interp_feeder #(.ISZ(ISZ), .CLK_DIV(CLK_DIV), .RATIO(RATIO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .out_rate(out_rate), .in_rate(in_rate), .out_data(out_data),
    .level(level), .underflow(underflow), .clear_underflow(clear_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       s_ready;
    bit       out_rate;
    bit       in_rate;
    bit       underflow;
    int       out_data;
    int       level;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: enabled-run length since enable rose, sample queue, held output, sticky flag.
  int             run_len = 0;
  logic [ISZ-1:0] mq[$];
  logic [ISZ-1:0] m_od = '0;
  bit             m_uf = 1'b0;

  function automatic bit m_out_rate();
    return (run_len > 0) && (run_len % CLK_DIV == 0);
  endfunction

  function automatic bit m_in_rate();
    return m_out_rate() && (((run_len / CLK_DIV) - 1) % RATIO == 0);
  endfunction

  task automatic model_step();
    bit irate;
    bit set;
    bit push;
    if (reset) begin
      run_len = 0;
      mq.delete();
      m_od = '0;
      m_uf = 1'b0;
    end else begin
      irate = m_in_rate();
      set   = 1'b0;
      push  = s_valid && (mq.size() < DEPTH);
      if (irate) begin
        if (mq.size() > 0) m_od = mq.pop_front();
        else begin
          m_od = '0;
          set  = 1'b1;
        end
      end
      if (set) m_uf = 1'b1;
      else if (clear_underflow) m_uf = 1'b0;
      if (push) mq.push_back(s_data);
      run_len = enable ? run_len + 1 : 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.s_ready   = !reset && (mq.size() < DEPTH);
    e.out_rate  = m_out_rate();
    e.in_rate   = m_in_rate();
    e.underflow = m_uf;
    e.out_data  = int'(m_od);
    e.level     = mq.size();
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp_v, input int cyc);
    checks++;
    if (act == exp_v) passes++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
  endtask

  initial begin : monitor
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("s_ready",   int'(s_ready),   int'(e.s_ready),   cyc);
        check("out_rate",  int'(out_rate),  int'(e.out_rate),  cyc);
        check("in_rate",   int'(in_rate),   int'(e.in_rate),   cyc);
        check("underflow", int'(underflow), int'(e.underflow), cyc);
        check("out_data",  int'(out_data),  e.out_data,        cyc);
        check("level",     int'(level),     e.level,           cyc);
        cyc++;
      end
    end
  end

  initial begin : driver
    int pv;
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      model_step();
      #1;
      case ((i / 500) % 4)
        0:       pv = 90;
        1:       pv = 15;
        2:       pv = 50;
        default: pv = 30;
      endcase
      if (i < 3) begin
        reset = 1'b1;
        enable = 1'b0;
      end else if (i < 12) begin
        // Fill past capacity with enable low, then start the strobes.
        reset = 1'b0;
        enable = 1'b0;
        pv = 100;
      end else begin
        reset = ($urandom_range(0, 299) == 0);
        if (i == 12 || $urandom_range(0, 39) == 0) enable = ~enable;
      end
      s_valid = ($urandom_range(1, 100) <= pv);
      case ($urandom_range(0, 7))
        0:       s_data = 16'h0001;
        1:       s_data = 16'h7FFF;
        2:       s_data = 16'h8000;
        3:       s_data = 16'hFFFF;
        default: s_data = ISZ'($urandom);
      endcase
      clear_underflow = ($urandom_range(0, 15) == 0);
      push_exp();
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
